// File: rtl/vend_pkg.sv
// Shared constants, channel indices and the fixed-priority grant helper
// for the vending-machine input conditioner.
package vend_pkg;

    localparam int N_COIN = 4;
    localparam int N_ITEM = 10;
    localparam int N_CH   = N_COIN + N_ITEM;

    typedef enum int {
        COIN_10 = 0,
        COIN_1  = 1,
        COIN_2  = 2,
        COIN_5  = 3
    } coin_idx_e;

    typedef enum int {
        ITEM_TEA     = 0,
        ITEM_COOKIES = 1,
        ITEM_COFFEE  = 2,
        ITEM_CANDY1  = 3,
        ITEM_CANDY2  = 4,
        ITEM_CANDY3  = 5,
        ITEM_CHOC1   = 6,
        ITEM_CHOC2   = 7,
        ITEM_CHOC3   = 8,
        ITEM_CHOC4   = 9
    } item_idx_e;

    // Coins occupy the low channel bits so they win arbitration over items
    typedef logic [N_CH-1:0] ch_vec_t;

    function automatic ch_vec_t prio_grant(input ch_vec_t req);
        return req & (~req + ch_vec_t'(1'b1));
    endfunction

endpackage

// File: rtl/vend_if.sv
// Raw button/switch inputs and conditioned event/level outputs of the
// input conditioner; the slave modport is the conditioner's view.
interface vend_if;
    import vend_pkg::*;

    logic [N_COIN-1:0] coin_raw;
    logic [1:0]        mode_raw;
    logic [N_ITEM-1:0] item_raw;
    logic              rr_raw;
    logic [N_COIN-1:0] coin_pulse;
    logic [N_ITEM-1:0] item_pulse;
    logic [1:0]        mode_lvl;
    logic              rr_lvl;
    logic              drop_pulse;

    modport master (
        output coin_raw, mode_raw, item_raw, rr_raw,
        input  coin_pulse, item_pulse, mode_lvl, rr_lvl, drop_pulse
    );

    modport slave (
        input  coin_raw, mode_raw, item_raw, rr_raw,
        output coin_pulse, item_pulse, mode_lvl, rr_lvl, drop_pulse
    );

endinterface

// File: rtl/vend_debounce.sv
// One input channel: 2-flop synchronizer followed by a DB_CNT-cycle debouncer
// (DEBOUNCE_EN defined) or a single register stage (DEBOUNCE_EN undefined).
module vend_debounce #(
    parameter int DB_CNT = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic raw,
    output logic db
);

    logic meta_r;
    logic sync_r;
    logic db_r;

    // Two-flop synchronizer for the asynchronous raw input
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

`ifdef DEBOUNCE_EN
    localparam logic [7:0] CNT_LAST = 8'(DB_CNT - 1);

    logic [7:0] cnt_r;

    // Accept the synchronized level only after DB_CNT consecutive disagreeing cycles
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= 8'd0;
            db_r  <= 1'b0;
        end else if (sync_r == db_r) begin
            cnt_r <= 8'd0;
        end else if (cnt_r == CNT_LAST) begin
            db_r  <= sync_r;
            cnt_r <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end
`else
    logic db_cnt_unused_s;
    assign db_cnt_unused_s = (DB_CNT > 0);

    // Single register stage keeps the level latency fixed at three clocks
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db_r <= 1'b0;
        end else begin
            db_r <= sync_r;
        end
    end
`endif

    assign db = db_r;

endmodule

// File: rtl/vend_input_conditioner.sv
// Conditions 17 raw vending inputs into one-hot coin/item event pulses and
// debounced levels. Debouncing is enabled by defining DEBOUNCE_EN.
module vend_input_conditioner
    import vend_pkg::*;
#(
    parameter int DB_CNT = 16
) (
    input logic   CLK,
    input logic   RST_N,
    vend_if.slave bus
);

    localparam int N_RAW = N_CH + 3;

    logic [N_RAW-1:0] raw_s;
    logic [N_RAW-1:0] db_s;
    ch_vec_t          ch_db_s;
    ch_vec_t          rise_s;
    ch_vec_t          grant_s;
    ch_vec_t          pend_nxt_s;
    ch_vec_t          db_q_r;
    ch_vec_t          pend_r;
    ch_vec_t          pulse_r;
    logic             drop_s;
    logic             drop_r;
    logic             rr_s;

    assign raw_s = {bus.rr_raw, bus.mode_raw, bus.item_raw, bus.coin_raw};

    for (genvar i = 0; i < N_RAW; i++) begin : g_in
        vend_debounce #(.DB_CNT(DB_CNT)) u_db (
            .CLK   (CLK),
            .RST_N (RST_N),
            .raw   (raw_s[i]),
            .db    (db_s[i])
        );
    end

    assign ch_db_s = db_s[N_CH-1:0];
    assign rr_s    = db_s[N_CH+2];

    // A press landing on its own grant cycle stays queued rather than dropped
    always_comb begin
        rise_s     = ch_db_s & ~db_q_r;
        grant_s    = prio_grant(pend_r);
        pend_nxt_s = (pend_r & ~grant_s) | rise_s;
        drop_s     = |(rise_s & pend_r & ~grant_s);
    end

    // Edge history, pending requests and registered one-hot grant
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            db_q_r  <= {N_CH{1'b0}};
            pend_r  <= {N_CH{1'b0}};
            pulse_r <= {N_CH{1'b0}};
            drop_r  <= 1'b0;
        end else begin
            db_q_r <= ch_db_s;
            if (rr_s) begin
                pend_r  <= {N_CH{1'b0}};
                pulse_r <= {N_CH{1'b0}};
                drop_r  <= 1'b0;
            end else begin
                pend_r  <= pend_nxt_s;
                pulse_r <= grant_s;
                drop_r  <= drop_s;
            end
        end
    end

    // Masking also covers the first cycle of return-change, when pulse_r still holds a grant
    assign bus.coin_pulse = rr_s ? {N_COIN{1'b0}} : pulse_r[N_COIN-1:0];
    assign bus.item_pulse = rr_s ? {N_ITEM{1'b0}} : pulse_r[N_CH-1:N_COIN];
    assign bus.mode_lvl   = db_s[N_CH+1:N_CH];
    assign bus.rr_lvl     = rr_s;
    assign bus.drop_pulse = drop_r;

endmodule

// File: tb/tb_vend_input_conditioner.sv
// Directed scoreboard bench for vend_input_conditioner (DB_CNT=4); expected
// pulse timing follows the DEBOUNCE_EN setting of the build.
module tb_vend_input_conditioner;
    import vend_pkg::*;

    localparam int DB = 4;
`ifdef DEBOUNCE_EN
    localparam int P_LAT = DB + 4;
    localparam int L_LAT = DB + 2;
`else
    localparam int P_LAT = 5;
    localparam int L_LAT = 3;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] coin;
        logic [9:0] item;
        logic       drop;
    } exp_t;

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    vend_if bus();

    vend_input_conditioner #(.DB_CNT(DB)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void push(input int t, input logic [3:0] c,
                                 input logic [9:0] i, input logic d);
        exp_t e;
        e.cyc  = t;
        e.coin = c;
        e.item = i;
        e.drop = d;
        exp_q.push_back(e);
    endfunction

    function automatic logic [17:0] outs();
        return {bus.coin_pulse, bus.item_pulse, bus.mode_lvl, bus.rr_lvl, bus.drop_pulse};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every cycle: pop entries due now; anything not expected must be zero
    task automatic sb_check();
        logic [3:0] ec;
        logic [9:0] ei;
        logic       ed;
        ec = 4'h0;
        ei = 10'h000;
        ed = 1'b0;
        for (int k = exp_q.size() - 1; k >= 0; k--) begin
            if (exp_q[k].cyc == cyc) begin
                ec = ec | exp_q[k].coin;
                ei = ei | exp_q[k].item;
                ed = ed | exp_q[k].drop;
                exp_q.delete(k);
            end
        end
        n_checks++;
        assert ({bus.coin_pulse, bus.item_pulse, bus.drop_pulse} === {ec, ei, ed})
        else begin
            n_errors++;
            $error("FAIL pulses cyc %0d: got coin=%b item=%b drop=%b expected coin=%b item=%b drop=%b",
                   cyc, bus.coin_pulse, bus.item_pulse, bus.drop_pulse, ec, ei, ed);
        end
    endtask

    task automatic tick(input int n);
        for (int s = 0; s < n; s++) begin
            @(negedge CLK);
            sb_check();
        end
    endtask

    // All 14 channels pressed at once; choc4 re-pressed after h cycles low
    task automatic batch(input int h);
        int c0;
        c0 = cyc;
        bus.coin_raw = 4'hF;
        bus.item_raw = 10'h3FF;
        for (int i = 0; i < 4; i++) push(c0 + P_LAT + i, 4'(1 << i), 10'h000, 1'b0);
        for (int j = 0; j < 9; j++) push(c0 + P_LAT + 4 + j, 4'h0, 10'(1 << j), 1'b0);
        push(c0 + P_LAT + 13, 4'h0, 10'h200, 1'b0);
        if (h == 6) push(c0 + P_LAT + 11, 4'h0, 10'h000, 1'b1);
        else        push(c0 + P_LAT + 14, 4'h0, 10'h200, 1'b0);
        tick(h);
        bus.item_raw[ITEM_CHOC4] = 1'b0;
        tick(h);
        bus.item_raw[ITEM_CHOC4] = 1'b1;
        tick(25);
        bus.coin_raw = 4'h0;
        bus.item_raw = 10'h000;
        tick(20);
    endtask

    initial begin
        int c0;
        bus.coin_raw = 4'h0;
        bus.item_raw = 10'h000;
        bus.mode_raw = 2'b00;
        bus.rr_raw   = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        chk("reset_outputs", 32'(outs()), 32'h0);
        tick(3);
        RST_N = 1'b1;
        tick(3);

        // Single coin held for 20 cycles: one pulse at P_LAT
        c0 = cyc;
        bus.coin_raw[COIN_1] = 1'b1;
        push(c0 + P_LAT, 4'b0010, 10'h000, 1'b0);
        tick(20);
        bus.coin_raw = 4'h0;
        tick(15);

        // Coin beats item pressed in the same cycle
        c0 = cyc;
        bus.coin_raw[COIN_5]      = 1'b1;
        bus.item_raw[ITEM_COFFEE] = 1'b1;
        push(c0 + P_LAT,     4'b1000, 10'h000, 1'b0);
        push(c0 + P_LAT + 1, 4'b0000, 10'h004, 1'b0);
        tick(15);
        bus.coin_raw = 4'h0;
        bus.item_raw = 10'h000;
        tick(15);

        // Mode level latency
        bus.mode_raw = 2'b10;
        tick(L_LAT - 1);
        chk("mode_before", 32'(bus.mode_lvl), 32'h0);
        tick(1);
        chk("mode_after", 32'(bus.mode_lvl), 32'h2);
        bus.mode_raw = 2'b00;
        tick(L_LAT);
        chk("mode_fall", 32'(bus.mode_lvl), 32'h0);
        tick(5);

`ifdef DEBOUNCE_EN
        // Press shorter than DB_CNT is filtered
        bus.item_raw[ITEM_TEA] = 1'b1;
        tick(3);
        bus.item_raw[ITEM_TEA] = 1'b0;
        tick(20);
`else
        // One-cycle glitch passes straight through
        c0 = cyc;
        bus.coin_raw[COIN_10] = 1'b1;
        push(c0 + 5, 4'b0001, 10'h000, 1'b0);
        tick(1);
        bus.coin_raw[COIN_10] = 1'b0;
        tick(15);
`endif

        batch(6);
        batch(7);

        // Return-change suppresses everything while high
        c0 = cyc;
        bus.rr_raw           = 1'b1;
        bus.coin_raw[COIN_2] = 1'b1;
        tick(L_LAT - 1);
        chk("rr_before", 32'(bus.rr_lvl), 32'h0);
        tick(1);
        chk("rr_after", 32'(bus.rr_lvl), 32'h1);
        tick(4);
        bus.item_raw[ITEM_CANDY3] = 1'b1;
        tick(12);
        bus.item_raw = 10'h000;
        bus.coin_raw = 4'h0;
        tick(12);
        bus.rr_raw = 1'b0;
        tick(L_LAT - 1);
        chk("rr_hold", 32'(bus.rr_lvl), 32'h1);
        tick(1);
        chk("rr_fall", 32'(bus.rr_lvl), 32'h0);
        tick(2);
        c0 = cyc;
        bus.item_raw[ITEM_CANDY3] = 1'b1;
        push(c0 + P_LAT, 4'h0, 10'h020, 1'b0);
        tick(12);
        bus.item_raw = 10'h000;
        tick(15);

        // Reset mid-debounce, inputs held high across release
        bus.mode_raw = 2'b11;
        tick(L_LAT + 1);
        chk("mode_held", 32'(bus.mode_lvl), 32'h3);
        bus.coin_raw[COIN_5] = 1'b1;
        tick(4);
        RST_N = 1'b0;
        #1;
        chk("reset_async", 32'(outs()), 32'h0);
        tick(3);
        RST_N = 1'b1;
        c0 = cyc;
        push(c0 + P_LAT, 4'b1000, 10'h000, 1'b0);
        tick(L_LAT - 1);
        chk("mode_post_reset_lo", 32'(bus.mode_lvl), 32'h0);
        tick(1);
        chk("mode_post_reset_hi", 32'(bus.mode_lvl), 32'h3);
        tick(15);
        bus.coin_raw = 4'h0;
        bus.mode_raw = 2'b00;
        tick(20);

        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vend_input_conditioner.md
VEND_INPUT_CONDITIONER -- requirements
Module: vend_input_conditioner

Interface
REQ-001 SHALL have parameter: DB_CNT, 16, debounce length in clocks, legal 2..255.
REQ-002 SHALL have port: CLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: coin_raw  input  4  raw coin buttons, bit0..3 = $10, $1, $2, $5.
REQ-005 SHALL have port: mode_raw  input  2  raw free-vend mode switches (level).
REQ-006 SHALL have port: item_raw  input  10  raw item buttons, bit0..9 = tea, cookies, coffee, candy1-3, choc1-4.
REQ-007 SHALL have port: rr_raw  input  1  raw return-change switch (level).
REQ-008 SHALL have port: coin_pulse  output  4  one-clock coin event, at most one bit high per cycle.
REQ-009 SHALL have port: item_pulse  output  10  one-clock item request; no bit high in a cycle where any coin_pulse bit is high.
REQ-010 SHALL have port: mode_lvl  output  2  debounced mode levels.
REQ-011 SHALL have port: rr_lvl  output  1  debounced return-change level.
REQ-012 SHALL have port: drop_pulse  output  1  one-clock flag, a press was discarded.

Function
REQ-013 Each of the 17 raw inputs SHALL pass through a 2-flop synchronizer, then a debouncer.
REQ-014 Debouncer: counter increments each cycle sync != db, clears when sync == db; reaching DB_CNT mismatched cycles -> db <= sync, counter <= 0.
REQ-015 Input held high for fewer than DB_CNT synchronized cycles SHALL produce no db change and no pulse.
REQ-016 Rising edge of a coin/item db value SHALL set that channel's pending bit; falling edges SHALL be ignored.
REQ-017 Arbiter SHALL grant one pending bit per cycle in fixed priority: coin bit0..3, then item bit0..9; granted bit cleared, one-hot pulse registered to output next cycle.
REQ-018 Uncontended latency, raw rise at cycle 0 held stable: pulse high in cycle DB_CNT+4, exactly one cycle wide.
REQ-019 mode_lvl and rr_lvl SHALL be db values directly, latency DB_CNT+2.
REQ-020 New edge on a channel whose pending bit is already set SHALL be discarded and assert drop_pulse for one cycle.
REQ-021 While rr_lvl high: all pending bits cleared, new edges discarded without drop_pulse, coin_pulse/item_pulse held 0.
REQ-022 Simultaneous edge set and grant on same channel SHALL leave pending set (new press queued).

Reset
REQ-023 RST_N low SHALL asynchronously clear synchronizers, db values, counters, pending bits and all outputs to 0.
REQ-024 Release of RST_N with raw inputs already high SHALL be treated as a new press after full debounce latency.

Configuration
REQ-025 With DEBOUNCE_EN defined: debounce per REQ-014, latency DB_CNT+4.
REQ-026 Without DEBOUNCE_EN: db = synchronizer output delayed one register, no counters, DB_CNT ignored, pulse latency 5, level latency 3.

Structure
REQ-027 Package vend_pkg SHALL hold N_COIN=4, N_ITEM=10, coin index constants (COIN_10, COIN_1, COIN_2, COIN_5) and item index constants.
REQ-028 Sub-module vend_debounce (one-channel synchronizer + debouncer, parameter DB_CNT) SHALL be instantiated 17 times.

Verification
REQ-029 DB_CNT=4, coin_raw[1] 0->1 held 20 cycles -> coin_pulse=4'b0010 in cycle 8 only.
REQ-030 DB_CNT=4, item_raw[0] high 3 cycles then low -> no pulse, drop_pulse stays 0.
REQ-031 coin_raw[3] and item_raw[2] rise same cycle -> coin_pulse[3] cycle 8, item_pulse[2] cycle 9.
REQ-032 rr_raw high then item_raw[5] press -> rr_lvl high cycle 6, no item_pulse, no drop_pulse; press after rr_lvl falls -> item_pulse[5] after DB_CNT+4.
REQ-033 RST_N asserted mid-debounce (cycle 4) -> all outputs 0 immediately; no pulse until full latency after release.
REQ-034 Build without DEBOUNCE_EN, 1-cycle coin_raw[0] glitch -> coin_pulse[0] in cycle 5.
